// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues sequential word fetches to instruction
// memory, buffers in-order responses with their PCs in a circular prefetch
// queue, and hands entries to decode. A redirect flushes the queue and marks
// every response still in flight as stale.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  // Stale responses from back-to-back redirects can pile up on top of a full
  // queue's worth of live requests, so the in-flight counters get headroom.
  localparam int unsigned CNT_W = PTR_W + 4;

  // Parameter sanity: DEPTH must be a power of two and at least 2.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ifetch_unit: DEPTH must be a power of two >= 2");
  end

  logic [31:0]      fetch_pc;
  logic [31:0]      slot_pc    [DEPTH];
  logic [31:0]      slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;
  logic [PTR_W-1:0] alloc_ptr;
  logic [PTR_W-1:0] fill_ptr;
  logic [PTR_W-1:0] head_ptr;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] in_flight;
  logic [CNT_W-1:0] discard;

  logic accept_c;
  logic rsp_live_c;
  logic rsp_drop_c;
  logic rsp_fill_c;
  logic pop_c;

  // Request channel and decode-side view of the head slot.
  always_comb begin
    imem_req_valid = rst && !redirect_valid && (occupancy < OCC_W'(DEPTH));
    imem_req_addr  = fetch_pc;
    id_valid       = slot_filled[head_ptr] && (occupancy != '0);
    id_pc          = slot_pc[head_ptr];
    id_instr       = slot_instr[head_ptr];
  end

  // Per-cycle events; a response with nothing in flight is a protocol error
  // and is ignored, and a redirect overrides filling and popping.
  always_comb begin
    accept_c   = imem_req_valid && imem_req_ready;
    rsp_live_c = imem_rsp_valid && (in_flight != '0);
    rsp_drop_c = rsp_live_c && (discard != '0);
    rsp_fill_c = rsp_live_c && (discard == '0) && !redirect_valid;
    pop_c      = id_valid && id_ready && !redirect_valid;
  end

  // Fetch address: sequential on acceptance, redirect target word-aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'h0000_0003;
    end else if (accept_c) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Queue pointers and occupancy (allocated slots, filled or not).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      occupancy <= '0;
    end else if (redirect_valid) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      occupancy <= '0;
    end else begin
      if (accept_c) begin
        alloc_ptr <= alloc_ptr + PTR_W'(1);
      end
      if (rsp_fill_c) begin
        fill_ptr <= fill_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      occupancy <= occupancy + OCC_W'(accept_c) - OCC_W'(pop_c);
    end
  end

  // Outstanding-request and stale-response counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight <= '0;
      discard   <= '0;
    end else begin
      in_flight <= in_flight + CNT_W'(accept_c) - CNT_W'(rsp_live_c);
      if (redirect_valid) begin
        discard <= in_flight - CNT_W'(rsp_live_c);
      end else if (rsp_drop_c) begin
        discard <= discard - CNT_W'(1);
      end
    end
  end

  // Slot storage: allocate on accept, fill on live response, clear on pop/flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_pc[i]    <= '0;
        slot_instr[i] <= '0;
      end
      slot_filled <= '0;
    end else if (redirect_valid) begin
      slot_filled <= '0;
    end else begin
      if (accept_c) begin
        slot_pc[alloc_ptr]     <= fetch_pc;
        slot_filled[alloc_ptr] <= 1'b0;
      end
      if (rsp_fill_c) begin
        slot_instr[fill_ptr]  <= imem_rsp_data;
        slot_filled[fill_ptr] <= 1'b1;
      end
      if (pop_c) begin
        slot_filled[head_ptr] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: an in-order memory model with variable
// latency feeds the DUT, and a stream-level reference model predicts the
// request addresses and the PC/instruction sequence seen by decode.
module tb_ifetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t mq[$];
  int    cyc;
  int    lat_min;
  int    lat_max;
  int    last_due;
  int    checks;
  int    errors;

  // Reference model: decode sees a gap-free PC run starting at the last
  // reset/redirect target; only responses to requests of the current epoch count.
  logic [31:0] m_fetch;
  logic [31:0] m_head;
  int          m_occ;
  int          m_avail;
  int          m_epoch;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic model_restart(input logic [31:0] pc);
    m_fetch = {pc[31:2], 2'b00};
    m_head  = {pc[31:2], 2'b00};
    m_occ   = 0;
    m_avail = 0;
    m_epoch = m_epoch + 1;
  endtask

  // One clock cycle: drive memory response, compare against model, advance.
  task automatic step(output bit acc);
    mreq_t e;
    logic  exp_rv;
    logic  exp_iv;
    int    lat;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq[0].addr);
    end
    #1;
    exp_rv = (!redirect_valid) && (m_occ < DEPTH);
    checks++;
    if (imem_req_valid !== exp_rv) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got %b exp %b", cyc, imem_req_valid, exp_rv);
    end
    exp_iv = (m_avail > 0);
    checks++;
    if (id_valid !== exp_iv) begin
      errors++;
      $display("FAIL id_valid cyc=%0d got %b exp %b", cyc, id_valid, exp_iv);
    end
    if (id_valid === 1'b1 && m_avail > 0) begin
      checks++;
      if (id_pc !== m_head) begin
        errors++;
        $display("FAIL id_pc cyc=%0d got %h exp %h", cyc, id_pc, m_head);
      end
      checks++;
      if (id_instr !== instr_of(m_head)) begin
        errors++;
        $display("FAIL id_instr cyc=%0d got %h exp %h", cyc, id_instr, instr_of(m_head));
      end
    end
    acc = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1);
    if (acc) begin
      checks++;
      if (imem_req_addr !== m_fetch) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got %h exp %h", cyc, imem_req_addr, m_fetch);
      end
      lat = $urandom_range(lat_max, lat_min);
      e.addr  = imem_req_addr;
      e.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      e.epoch = m_epoch;
      last_due = e.due;
      mq.push_back(e);
      m_fetch = m_fetch + 32'd4;
      m_occ++;
    end
    if (id_valid === 1'b1 && id_ready && !redirect_valid && m_avail > 0) begin
      m_head = m_head + 32'd4;
      m_avail--;
      m_occ--;
    end
    if (imem_rsp_valid) begin
      e = mq.pop_front();
      if (e.epoch == m_epoch && !redirect_valid) m_avail++;
    end
    if (redirect_valid) model_restart(redirect_pc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Assert reset (asynchronously from the caller's point of view) and hold it.
  task automatic apply_reset();
    rst            = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    mq.delete();
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_valid got %b exp 0", imem_req_valid);
    end
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_id_valid got %b exp 0", id_valid);
    end
    checks++;
    if (imem_req_addr !== RPC) begin
      errors++;
      $display("FAIL rst_req_addr got %h exp %h", imem_req_addr, RPC);
    end
    checks++;
    if (id_pc !== 32'h0 || id_instr !== 32'h0) begin
      errors++;
      $display("FAIL rst_id_data got pc=%h instr=%h exp 0/0", id_pc, id_instr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b1;
    last_due = cyc;
    model_restart(RPC);
  endtask

  task automatic test_reset();
    bit a;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    redirect_pc    = 32'h0;
    lat_min = 1;
    lat_max = 1;
    apply_reset();
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      errors++;
      $display("FAIL first_req got v=%b a=%h exp 1/%h", imem_req_valid, imem_req_addr, RPC);
    end
    step(a);
  endtask

  task automatic test_sequential();
    bit a;
    int valid_cnt;
    apply_reset();
    lat_min = 1;
    lat_max = 1;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    valid_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(a);
      if (i >= 1 && id_valid === 1'b1) valid_cnt++;
    end
    checks++;
    if (valid_cnt != 15) begin
      errors++;
      $display("FAIL seq_throughput got %0d exp 15", valid_cnt);
    end
  endtask

  task automatic test_stall();
    bit a;
    int n_acc;
    int n_pop;
    apply_reset();
    lat_min = 1;
    lat_max = 1;
    imem_req_ready = 1'b1;
    id_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(a);
      if (a) n_acc++;
    end
    checks++;
    if (n_acc != DEPTH) begin
      errors++;
      $display("FAIL stall_issue_count got %0d exp %0d", n_acc, DEPTH);
    end
    checks++;
    if (id_pc !== RPC || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got pc=%h rv=%b exp %h/0", id_pc, imem_req_valid, RPC);
    end
    id_ready = 1'b1;
    n_pop = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (id_valid === 1'b1) n_pop++;
      step(a);
    end
    checks++;
    if (n_pop != DEPTH) begin
      errors++;
      $display("FAIL stall_release_pops got %0d exp %0d", n_pop, DEPTH);
    end
    for (int i = 0; i < 6; i++) step(a);
  endtask

  task automatic test_redirect_inflight();
    bit a;
    bit seen;
    apply_reset();
    lat_min = 4;
    lat_max = 4;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(a);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    step(a);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_next got v=%b a=%h idv=%b exp 1/200/0",
               imem_req_valid, imem_req_addr, id_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(a);
      if (id_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (id_pc !== 32'h200) begin
          errors++;
          $display("FAIL redir_first_pc got %h exp 00000200", id_pc);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL redir_first_pc timeout got none exp 00000200");
    end
    for (int i = 0; i < 6; i++) step(a);
  endtask

  task automatic test_redirect_rsp();
    bit a;
    apply_reset();
    lat_min = 2;
    lat_max = 2;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) step(a);
    checks++;
    if (mq.size() != 2 || mq[0].due != cyc) begin
      errors++;
      $display("FAIL redir_rsp_setup got outstanding=%0d exp 2 with response due", mq.size());
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    step(a);
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) step(a);
  endtask

  task automatic test_backpressure();
    bit a;
    int n_acc;
    apply_reset();
    lat_min = 1;
    lat_max = 1;
    id_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      imem_req_ready = (i % 4 == 0) || (i % 4 == 3);
      step(a);
      if (a) n_acc++;
    end
    checks++;
    if (n_acc != 8) begin
      errors++;
      $display("FAIL bp_accepts got %0d exp 8", n_acc);
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(a);
  endtask

  task automatic test_random();
    bit a;
    apply_reset();
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 500; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      id_ready       = ($urandom_range(9, 0) < 7);
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc    = $urandom;
      step(a);
    end
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) step(a);
  endtask

  task automatic test_async_reset();
    bit a;
    apply_reset();
    lat_min = 1;
    lat_max = 1;
    imem_req_ready = 1'b1;
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(a);
    checks++;
    if (id_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got id_valid=%b exp 1", id_valid);
    end
    #3;
    apply_reset();
    id_ready = 1'b1;
    #1;
    checks++;
    if (imem_req_addr !== RPC || imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_restart got v=%b a=%h exp 1/%h", imem_req_valid, imem_req_addr, RPC);
    end
    for (int i = 0; i < 8; i++) step(a);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    cyc            = 0;
    last_due       = 0;
    m_epoch        = 0;
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_restart(RPC);
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_inflight();
    test_redirect_rsp();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
